// File: rtl/sphere_collide_sched_if.sv
// sphere_collide_sched_if: requester, engine and response signals of the collision scheduler
interface sphere_collide_sched_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*256-1:0] req_pair;
    logic [255:0]        eng_pair;
    logic                eng_start;
    logic                eng_abort;
    logic                eng_done;
    logic                eng_ret;
    logic [223:0]        eng_res;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [2:0]          rsp_id;
    logic                rsp_ret;
    logic                rsp_err;
    logic [223:0]        rsp_res;
    logic [15:0]         hit_count;
    modport master (
        output req_valid, req_pair, eng_done, eng_ret, eng_res, rsp_ready,
        input  req_ready, eng_pair, eng_start, eng_abort, rsp_valid, rsp_id, rsp_ret, rsp_err, rsp_res, hit_count
    );
    modport slave (
        input  req_valid, req_pair, eng_done, eng_ret, eng_res, rsp_ready,
        output req_ready, eng_pair, eng_start, eng_abort, rsp_valid, rsp_id, rsp_ret, rsp_err, rsp_res, hit_count
    );
endinterface

// File: rtl/sphere_collide_sched.sv
// sphere_collide_sched: round-robin sharing of one sphere-pair collision engine with per-job timeout
module sphere_collide_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    sphere_collide_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, RESP} state_t;
    state_t      state;
    logic [2:0]  last;
    logic [2:0]  gnt_idx;
    logic        gnt_any;
    logic [15:0] cnt;
    // Scan downward so the valid requester closest after last is the one kept
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (bus.req_valid[(int'(last) + i) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = 3'((int'(last) + i) % NREQ);
            end
        end
    end
    assign bus.req_ready = (state == IDLE && gnt_any) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx : '0;
    // cnt reads 0 in ISSUE, so it reaches TIMEOUT-1 on the TIMEOUT-th cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last          <= 3'(NREQ - 1);
            cnt           <= '0;
            bus.eng_pair  <= '0;
            bus.eng_start <= 1'b0;
            bus.eng_abort <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_ret   <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_res   <= '0;
            bus.hit_count <= '0;
        end else begin
            bus.eng_start <= 1'b0;
            bus.eng_abort <= 1'b0;
            case (state)
                IDLE: if (gnt_any) begin
                    bus.eng_pair  <= bus.req_pair[gnt_idx*256 +: 256];
                    bus.rsp_id    <= gnt_idx;
                    last          <= gnt_idx;
                    bus.eng_start <= 1'b1;
                    cnt           <= '0;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= cnt + 16'd1;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (bus.eng_done) begin
                        bus.rsp_ret   <= bus.eng_ret;
                        bus.rsp_res   <= bus.eng_res;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        bus.eng_abort <= 1'b1;
                        state         <= ABORT;
                    end
                end
                ABORT: begin
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_ret   <= 1'b0;
                    bus.rsp_res   <= '0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    if (bus.rsp_ret && bus.hit_count != 16'hFFFF) bus.hit_count <= bus.hit_count + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sphere_collide_sched.sv
// tb_sphere_collide_sched: scoreboard bench with a latency-programmable engine model
module tb_sphere_collide_sched;
    localparam int NREQ = 4;
    localparam int TO   = 16;
    typedef struct {
        logic [2:0]   id;
        logic         ret;
        logic         err;
        logic [223:0] res;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sphere_collide_sched_if #(.NREQ(NREQ)) bus();
    sphere_collide_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    exp_t q[$];
    int total = 0, bad = 0, cyc = 0;
    int eng_lat = 0, cd = 0;
    int abort_cnt = 0, start_cnt = 0, start_cyc = -1, abort_cyc = -1, rsp_cyc = -1;
    logic spur = 1'b0, prev_v = 1'b0;
    logic [15:0] exp_hits = '0;
    logic [255:0] pairs [NREQ];

    function automatic logic [223:0] model_res(input logic [255:0] p);
        return p[255:32] ^ {7{32'h5a5a_a5a5}};
    endfunction
    function automatic logic model_ret(input logic [255:0] p);
        return |p[31:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // engine: done L cycles after the start pulse, never when L=0
    initial forever begin
        @(negedge clk);
        bus.eng_done = spur;
        if (rst || bus.eng_abort) cd = 0;
        else if (bus.eng_start) begin
            cd = eng_lat;
            bus.eng_ret = model_ret(bus.eng_pair);
            bus.eng_res = model_res(bus.eng_pair);
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) bus.eng_done = 1'b1;
        end
    end

    // event log and response scoreboard
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (bus.eng_start) begin start_cnt++; start_cyc = cyc; end
        if (bus.eng_abort) begin abort_cnt++; abort_cyc = cyc; end
        if (bus.rsp_valid && !prev_v) rsp_cyc = cyc;
        prev_v = bus.rsp_valid;
        if (rst) exp_hits = '0;
        else if (bus.rsp_valid && bus.rsp_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got id=%0d err=%0d exp no response", bus.rsp_id, bus.rsp_err);
            end else begin
                e = q.pop_front();
                if ({bus.rsp_id, bus.rsp_ret, bus.rsp_err, bus.rsp_res} !== {e.id, e.ret, e.err, e.res}) begin
                    bad++;
                    $display("FAIL rsp_fields got id=%0d ret=%0d err=%0d res=%h exp id=%0d ret=%0d err=%0d res=%h",
                             bus.rsp_id, bus.rsp_ret, bus.rsp_err, bus.rsp_res, e.id, e.ret, e.err, e.res);
                end
                if (e.ret) exp_hits++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1);
    end

    task automatic set_pairs();
        for (int i = 0; i < NREQ; i++) bus.req_pair[i*256 +: 256] = pairs[i];
    endtask

    task automatic drain(input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (q.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
            #3;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.eng_start, bus.eng_abort, bus.rsp_valid, bus.rsp_ret, bus.rsp_err, bus.rsp_id} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got rdy=%b st=%b ab=%b v=%b ret=%b err=%b id=%0d exp all 0", bus.req_ready,
                     bus.eng_start, bus.eng_abort, bus.rsp_valid, bus.rsp_ret, bus.rsp_err, bus.rsp_id);
        end
        total++;
        if (bus.eng_pair !== '0) begin bad++; $display("FAIL reset_eng_pair got %h exp 0", bus.eng_pair); end
        total++;
        if (bus.rsp_res !== '0) begin bad++; $display("FAIL reset_rsp_res got %h exp 0", bus.rsp_res); end
        total++;
        if (bus.hit_count !== 16'd0) begin bad++; $display("FAIL reset_hit_count got %0d exp 0", bus.hit_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int g;
        bit ok;
        @(negedge clk);
        eng_lat = 5;
        bus.rsp_ready = 1'b1;
        pairs[2] = {32'h0, 32'h0, 32'h0, 32'h3f80_0000, 32'h3f80_0000, 32'h0, 32'h0, 32'h3f80_0000};
        set_pairs();
        q.push_back('{3'd2, 1'b1, 1'b0, model_res(pairs[2])});
        bus.req_valid = 4'b0100;
        #1;
        g = cyc;
        total++;
        if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got %b exp 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        drain(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout got no response exp response"); end
        total++;
        if (start_cyc !== g + 1) begin bad++; $display("FAIL single_start_lat got %0d exp 1", start_cyc - g); end
        total++;
        if (rsp_cyc !== g + 7) begin bad++; $display("FAIL single_rsp_lat got %0d exp 7", rsp_cyc - g); end
        @(negedge clk);
        #1;
        total++;
        if (bus.hit_count !== 16'd1) begin bad++; $display("FAIL single_hit_count got %0d exp 1", bus.hit_count); end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int n = 0;
        bit ok;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        eng_lat = 3;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            q.push_back('{3'(order[i]), model_ret(pairs[order[i]]), 1'b0, model_res(pairs[order[i]])});
        bus.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 200 && n < 6; k++) begin
            if (|bus.req_ready) begin
                total++;
                if (bus.req_ready !== 4'(1 << order[n])) begin
                    bad++;
                    $display("FAIL rr_grant%0d got %b exp %b", n, bus.req_ready, 4'(1 << order[n]));
                end
                n++;
            end
            if (n < 6) begin @(negedge clk); #1; end
        end
        total++;
        if (n != 6) begin bad++; $display("FAIL rr_grant_count got %0d exp 6", n); end
        @(negedge clk);
        bus.req_valid = '0;
        drain(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_drain got %0d pending exp 0", q.size()); end
        @(negedge clk);
        #3;
        total++;
        if (bus.hit_count !== exp_hits) begin bad++; $display("FAIL rr_hit_count got %0d exp %0d", bus.hit_count, exp_hits); end
    endtask

    task automatic test_timeout();
        int g, a0;
        logic [15:0] h0;
        bit ok;
        @(negedge clk);
        eng_lat = 0;
        a0 = abort_cnt;
        h0 = bus.hit_count === exp_hits ? exp_hits : exp_hits;
        q.push_back('{3'd3, 1'b0, 1'b1, 224'd0});
        bus.req_valid = 4'b1000;
        #1;
        g = cyc;
        total++;
        if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL to_grant got %b exp 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_no_response got none exp error response"); end
        total++;
        if (abort_cnt !== a0 + 1) begin bad++; $display("FAIL to_abort_count got %0d exp 1", abort_cnt - a0); end
        total++;
        if (abort_cyc !== start_cyc + TO) begin bad++; $display("FAIL to_abort_lat got %0d exp %0d", abort_cyc - start_cyc, TO); end
        total++;
        if (rsp_cyc !== g + 2 + TO) begin bad++; $display("FAIL to_rsp_lat got %0d exp %0d", rsp_cyc - g, 2 + TO); end
        @(negedge clk);
        #3;
        total++;
        if (bus.hit_count !== h0) begin bad++; $display("FAIL to_hit_count got %0d exp %0d", bus.hit_count, h0); end
    endtask

    task automatic test_boundary();
        int g, a0;
        bit ok;
        @(negedge clk);
        eng_lat = TO - 1;
        a0 = abort_cnt;
        q.push_back('{3'd0, model_ret(pairs[0]), 1'b0, model_res(pairs[0])});
        bus.req_valid = 4'b0001;
        #1;
        g = cyc;
        total++;
        if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bnd_grant got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bnd_no_response got none exp response"); end
        total++;
        if (abort_cnt !== a0) begin bad++; $display("FAIL bnd_abort got %0d aborts exp 0", abort_cnt - a0); end
        total++;
        if (rsp_cyc !== g + 1 + TO) begin bad++; $display("FAIL bnd_rsp_lat got %0d exp %0d", rsp_cyc - g, 1 + TO); end
    endtask

    task automatic test_backpressure();
        int s0, r;
        bit ok, seen = 1'b0;
        @(negedge clk);
        eng_lat = 2;
        bus.rsp_ready = 1'b0;
        q.push_back('{3'd2, model_ret(pairs[2]), 1'b0, model_res(pairs[2])});
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = bus.rsp_valid;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_no_rsp got rsp_valid=0 exp 1"); end
        s0 = start_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #3;
            total++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_res, bus.req_ready} !== {1'b1, 3'd2, 1'b0, model_res(pairs[2]), 4'b0000}
                || start_cnt != s0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b id=%0d rdy=%b starts=%0d exp v=1 id=2 rdy=0000 starts=0",
                         k, bus.rsp_valid, bus.rsp_id, bus.req_ready, start_cnt - s0);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        q.push_back('{3'd1, model_ret(pairs[1]), 1'b0, model_res(pairs[1])});
        #1;
        r = cyc;
        total++;
        if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_accept_rdy got %b exp 0000", bus.req_ready); end
        @(negedge clk);
        #1;
        total++;
        if (bus.req_ready !== 4'b0010 || cyc != r + 1) begin
            bad++;
            $display("FAIL bp_regrant got %b at +%0d exp 0010 at +1", bus.req_ready, cyc - r);
        end
        @(negedge clk);
        bus.req_valid = '0;
        drain(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_drain got %0d pending exp 0", q.size()); end
    endtask

    task automatic test_reset_midjob();
        int a0;
        bit ok;
        @(negedge clk);
        eng_lat = 0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rm_grant got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        a0 = abort_cnt;
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.eng_start, bus.eng_abort, bus.rsp_valid, bus.rsp_ret, bus.rsp_err, bus.rsp_id,
             bus.eng_pair, bus.rsp_res, bus.hit_count} !== '0) begin
            bad++;
            $display("FAIL rm_reset_outputs got v=%b id=%0d hits=%0d pair=%h exp all 0", bus.rsp_valid, bus.rsp_id,
                     bus.hit_count, bus.eng_pair);
        end
        rst = 1'b0;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            total++;
            if ({bus.rsp_valid, bus.eng_start, bus.eng_abort} !== 3'b000 || abort_cnt != a0) begin
                bad++;
                $display("FAIL rm_idle%0d got v=%b st=%b ab=%b aborts=%0d exp 0 0 0 0", k, bus.rsp_valid,
                         bus.eng_start, bus.eng_abort, abort_cnt - a0);
            end
        end
        @(negedge clk);
        eng_lat = 1;
        q.push_back('{3'd0, model_ret(pairs[0]), 1'b0, model_res(pairs[0])});
        bus.req_valid = 4'b0011;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rm_next_grant got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        drain(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rm_drain got %0d pending exp 0", q.size()); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_pair  = '0;
        bus.eng_done  = 1'b0;
        bus.eng_ret   = 1'b0;
        bus.eng_res   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) pairs[i] = {8{$urandom}};
        pairs[0][31:0] = 32'h4000_0000;
        pairs[1][31:0] = 32'h0;
        pairs[3][31:0] = 32'h3f00_0000;
        set_pairs();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_boundary();
        test_backpressure();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sphere_collide_sched.md
# sphere_collide_sched

Round-robin scheduler that shares one sphere-pair collision engine among `NREQ` requesters. It accepts packed sphere-pair jobs over valid/ready, issues one job at a time to the engine with a start pulse, and waits for the engine's done pulse. It then returns the contact result tagged with the requester id, and aborts and error-flags any job that exceeds a cycle budget. It sits between the physics front-end job queues and the collision engine.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: max engine cycles per job, 2..65535.
- `clk` in 1: the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester job valid.
- `req_ready` out NREQ: one-hot accept; high for one cycle on grant.
- `req_pair` in NREQ*256: per requester {x1,y1,z1,r1,x2,y2,z2,r2}, IEEE-754 single precision, x1 in the MSBs.
- `eng_pair` out 256: latched job to the engine.
- `eng_start` out 1: one-cycle start pulse.
- `eng_abort` out 1: one-cycle abort pulse on timeout.
- `eng_done` in 1: engine completion pulse.
- `eng_ret` in 1: engine collide flag.
- `eng_res` in 224: {cx,cy,cz,normalx,normaly,normalz,depth}.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out 3: granted requester index.
- `rsp_ret` out 1: collide flag; 0 on error.
- `rsp_err` out 1: timeout flag.
- `rsp_res` out 224: contact result; all-zero on error.
- `hit_count` out 16: saturating count of responses with `rsp_ret`=1.

## Operation
- States and transitions:
  - IDLE: stay while no `req_valid`. Otherwise grant the first valid requester searching from `last+1` modulo NREQ. Pulse that requester's `req_ready`, latch `req_pair` into `eng_pair`, record the index in `rsp_id` and `last`, go to ISSUE.
  - ISSUE: `eng_start`=1 for exactly one cycle, clear the 16-bit cycle counter, go to WAIT.
  - WAIT: increment the counter each cycle.
    - On `eng_done`: latch `eng_ret` and `eng_res`, clear `rsp_err`, go to RESP.
    - When counter = TIMEOUT-1 and `eng_done`=0: pulse `eng_abort`, set `rsp_err`=1, `rsp_ret`=0, `rsp_res`=0, go to RESP.
    - `eng_done` on the timeout cycle counts as a normal completion; no abort.
  - RESP: hold `rsp_valid`=1 and keep all rsp fields stable until `rsp_ready`=1. On the accepting cycle, increment `hit_count` if `rsp_ret`=1 (saturate at 16'hFFFF), then go to IDLE.
- `eng_done` outside WAIT is ignored. This includes `eng_done` in the same cycle as `eng_start`.
- `req_ready` is high only in IDLE on the grant cycle, for one bit at most. A requester deasserting `req_valid` without a grant is legal.
- Fairness: a continuously valid requester waits at most NREQ-1 other jobs.
- The block does not interpret the float data; it moves it only.

## Timing
- Reset, applied at the clock edge with `rst`=1:
  - State = IDLE, `last` = NREQ-1, so requester 0 wins first.
  - `req_ready`, `eng_start`, `eng_abort`, `rsp_valid`, `rsp_ret`, `rsp_err` = 0.
  - `rsp_id` = 0, `eng_pair` = 0, `rsp_res` = 0, `hit_count` = 0.
- Reset mid-job drops the job silently and does not pulse `eng_abort`. The integration ties `rst` to the engine reset.
- Grant at cycle T → `eng_start` at T+1.
- `eng_done` at T+1+L (L ≥ 1) → `rsp_valid` at T+2+L.
- Minimum grant-to-`rsp_valid` latency is 3 cycles.
- After a timeout, `eng_abort` is asserted at T+1+TIMEOUT and `rsp_valid` at T+2+TIMEOUT.
- Response accepted at cycle R → earliest next grant at R+1, and its `eng_start` at R+2.
- All outputs are registered, except that `req_ready` may be decoded from state and the grant.

## Test plan
- Single job: reset, then `req_valid`=4'b0100 with a pair whose spheres are 1.0 apart with radii 1.0 each. Engine model returns done after 5 cycles with ret=1 → `eng_start` 1 cycle after grant, `rsp_id`=2, `rsp_ret`=1, `rsp_res` equals the model value, `rsp_valid` 7 cycles after grant, `hit_count`=1.
- Round-robin: all four requesters valid continuously, engine latency 3, `rsp_ready`=1 → grant order 0,1,2,3,0,1; no requester is granted twice within four jobs.
- Timeout: TIMEOUT=16 and the engine never sends done → `eng_abort` pulses exactly once, 16 cycles after `eng_start`. Response has `rsp_err`=1, `rsp_ret`=0, `rsp_res`=0, and `hit_count` is unchanged.
- Done on the timeout boundary: `eng_done` in the same cycle the counter reaches TIMEOUT-1 → no abort, `rsp_err`=0, and the result is latched.
- Backpressure: `rsp_ready` held at 0 for 10 cycles while requester 1 is valid → the response is held stable, no second grant and no `req_ready` occur, and the grant to 1 comes one cycle after acceptance.
- Reset in WAIT, plus a spurious `eng_done` in IDLE → all outputs return to reset values and no response is produced. The next request is granted to requester 0.
